cbm_writeback_queue: RTL and testbench

//  Downstream of the column-bypass multiplier. Captures each one-cycle CBM result pulse (done/result/rd)

---
 rtl/cbm_pkg.sv | 23 ++
 rtl/cbm_result_fifo.sv | 68 ++++++
 rtl/cbm_writeback_queue.sv | 121 ++++++++++++
 tb/tb_cbm_writeback_queue.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cbm_pkg.sv
// Shared types and constants for the column-bypass multiplier and its writeback path.
package cbm_pkg;

    localparam int CBM_RD_W   = 5;
    localparam int CBM_DATA_W = 32;

    // One queued writeback: destination register and the low product word.
    typedef struct packed {
        logic [CBM_RD_W-1:0]   rd;
        logic [CBM_DATA_W-1:0] value;
    } cbm_wb_entry_t;

    // Multiplier control-state encodings, shared so debug views decode alike.
    localparam logic [1:0] CBM_STATE_IDLE = 2'd0;
    localparam logic [1:0] CBM_STATE_BUSY = 2'd1;
    localparam logic [1:0] CBM_STATE_DONE = 2'd2;

    // One-hot register mask for a destination index.
    function automatic logic [31:0] cbm_rd_onehot(input logic [CBM_RD_W-1:0] rd);
        return 32'(1) << rd;
    endfunction

endpackage

// File: rtl/cbm_result_fifo.sv
// Small register FIFO holding CBM results until the RF write port is free.
// A push into a full FIFO is accepted only when a pop happens at the same edge.
module cbm_result_fifo
    import cbm_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  cbm_wb_entry_t            push_data_i,
    input  logic                     pop_i,
    output cbm_wb_entry_t            head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);

    cbm_wb_entry_t     mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              do_push, do_pop;

    assign full_o  = (count_q == CNT_FULL);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // When full, tail and head share a slot; the old head is read out before the edge overwrites it.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Next pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (do_push && !do_pop)      count_d = count_q + CNT_ONE;
        else if (!do_push && do_pop) count_d = count_q - CNT_ONE;
    end

    // Pointer and count registers.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care while unoccupied, so no reset.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/cbm_writeback_queue.sv
// Queues CBM result pulses and drains them into the shared RF write port,
// tracking outstanding MUL destinations and protecting the queue from starvation.
//
// Handshake: cbm_done_i has no ready; issue_stall_o is the only back-pressure and
// keeps one slot free for the op already in flight. The RF port belongs to the main
// pipe whenever wb_pipe_valid_i is high, except in a cycle after pipe_hold_o, when
// the queue takes it regardless.
module cbm_writeback_queue
    import cbm_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        issue_valid_i,
    input  logic [4:0]  issue_rd_idx_i,
    input  logic        cbm_done_i,
    input  logic [31:0] cbm_result_i,
    input  logic [4:0]  cbm_rd_idx_i,
    input  logic        wb_pipe_valid_i,
    output logic        wb_valid_o,
    output logic [4:0]  wb_rd_idx_o,
    output logic [31:0] wb_value_o,
    output logic [31:0] pending_rd_mask_o,
    output logic        issue_stall_o,
    output logic        pipe_hold_o,
    output logic        overflow_o
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] STALL_LEVEL = (ADDR_W+1)'(DEPTH-1);
    localparam logic [7:0]      STARVE_MAX  = 8'(STARVE_LIMIT);

    cbm_wb_entry_t   push_data, head;
    logic            full, empty;
    logic [ADDR_W:0] count;
    logic            deq, drop;

    logic            wb_valid_q, wb_valid_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic [31:0]     wb_value_q, wb_value_d;
    logic [31:0]     mask_q, mask_d;
    logic [7:0]      starve_q, starve_d;
    logic            hold_q, hold_d;
    logic            ovf_q, ovf_d;

    assign push_data = '{rd: cbm_rd_idx_i, value: cbm_result_i};

    cbm_result_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (cbm_done_i),
        .push_data_i (push_data),
        .pop_i       (deq),
        .head_o      (head),
        .full_o      (full),
        .empty_o     (empty),
        .count_o     (count)
    );

    assign deq  = !empty && (!wb_pipe_valid_i || hold_q);
    assign drop = cbm_done_i && full && !deq;

    // Next state for writeback registers, scoreboard, starve counter and overflow flag.
    always_comb begin
        wb_valid_d = deq && (head.rd != '0);
        wb_rd_d    = wb_rd_q;
        wb_value_d = wb_value_q;
        if (deq) begin
            wb_rd_d    = head.rd;
            wb_value_d = head.value;
        end

        // Clears first so that a same-cycle issue to the same rd wins.
        mask_d = mask_q;
        if (wb_valid_q) mask_d = mask_d & ~cbm_rd_onehot(wb_rd_q);
        if (drop)       mask_d = mask_d & ~cbm_rd_onehot(cbm_rd_idx_i);
        if (issue_valid_i && (issue_rd_idx_i != '0))
            mask_d = mask_d | cbm_rd_onehot(issue_rd_idx_i);
        mask_d[0] = 1'b0;

        // A non-empty queue that does not dequeue is necessarily blocked by the pipe.
        starve_d = starve_q;
        if (empty || deq)              starve_d = '0;
        else if (starve_q != STARVE_MAX) starve_d = starve_q + 8'd1;
        hold_d = (starve_d == STARVE_MAX);

        ovf_d = ovf_q || drop;
    end

    // State registers.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_value_q <= '0;
            mask_q     <= '0;
            starve_q   <= '0;
            hold_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_value_q <= wb_value_d;
            mask_q     <= mask_d;
            starve_q   <= starve_d;
            hold_q     <= hold_d;
            ovf_q      <= ovf_d;
        end
    end

    assign wb_valid_o        = wb_valid_q;
    assign wb_rd_idx_o       = wb_rd_q;
    assign wb_value_o        = wb_value_q;
    assign pending_rd_mask_o = mask_q;
    assign issue_stall_o     = (count >= STALL_LEVEL);
    assign pipe_hold_o       = hold_q;
    assign overflow_o        = ovf_q;

endmodule

// File: tb/tb_cbm_writeback_queue.sv
// Directed bench for cbm_writeback_queue: a one-cycle-per-record vector table,
// then hand-written sequences for starvation, overflow, full-FIFO bypass and reset.
module tb_cbm_writeback_queue;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        issue_valid_i;
    logic [4:0]  issue_rd_idx_i;
    logic        cbm_done_i;
    logic [31:0] cbm_result_i;
    logic [4:0]  cbm_rd_idx_i;
    logic        wb_pipe_valid_i;
    logic        wb_valid_o;
    logic [4:0]  wb_rd_idx_o;
    logic [31:0] wb_value_o;
    logic [31:0] pending_rd_mask_o;
    logic        issue_stall_o;
    logic        pipe_hold_o;
    logic        overflow_o;

    cbm_writeback_queue #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
        .clk_i             (clk),
        .rst_i             (rst_i),
        .issue_valid_i     (issue_valid_i),
        .issue_rd_idx_i    (issue_rd_idx_i),
        .cbm_done_i        (cbm_done_i),
        .cbm_result_i      (cbm_result_i),
        .cbm_rd_idx_i      (cbm_rd_idx_i),
        .wb_pipe_valid_i   (wb_pipe_valid_i),
        .wb_valid_o        (wb_valid_o),
        .wb_rd_idx_o       (wb_rd_idx_o),
        .wb_value_o        (wb_value_o),
        .pending_rd_mask_o (pending_rd_mask_o),
        .issue_stall_o     (issue_stall_o),
        .pipe_hold_o       (pipe_hold_o),
        .overflow_o        (overflow_o)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_vec = 0;
    int n_bad = 0;
    logic [36:0] exp_q[$];   // {rd, value} expected on the RF port, in order

    typedef struct {
        logic        rst;
        logic        iv;
        logic [4:0]  ird;
        logic        dn;
        logic [4:0]  drd;
        logic [31:0] dval;
        logic        pv;
        logic        ewb;
        logic [4:0]  erd;
        logic [31:0] eval;
        logic [31:0] emask;
        logic        estall;
        logic        ehold;
        logic        eovf;
    } vec_t;
    vec_t vecs[$];

    function automatic void add_vec(input logic rst, input logic iv, input logic [4:0] ird,
                                    input logic dn, input logic [4:0] drd, input logic [31:0] dval,
                                    input logic pv, input logic ewb, input logic [4:0] erd,
                                    input logic [31:0] eval, input logic [31:0] emask,
                                    input logic estall, input logic ehold, input logic eovf);
        vec_t v;
        v.rst = rst; v.iv = iv; v.ird = ird; v.dn = dn; v.drd = drd; v.dval = dval; v.pv = pv;
        v.ewb = ewb; v.erd = erd; v.eval = eval; v.emask = emask;
        v.estall = estall; v.ehold = ehold; v.eovf = eovf;
        vecs.push_back(v);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [4:0] ird, input logic dn,
                         input logic [4:0] drd, input logic [31:0] dval, input logic pv);
        issue_valid_i   = iv;
        issue_rd_idx_i  = ird;
        cbm_done_i      = dn;
        cbm_rd_idx_i    = drd;
        cbm_result_i    = dval;
        wb_pipe_valid_i = pv;
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        step();
        rst_i = 1'b1;
    endtask

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: drain with the port free and match every write against exp_q.
    task automatic drain(input string name, input int budget);
        int cyc = 0;
        drive(0, 0, 0, 0, 0, 0);
        while (exp_q.size() > 0 && cyc < budget) begin
            step();
            cyc++;
            if (wb_valid_o) chk(name, {wb_rd_idx_o, wb_value_o}, exp_q.pop_front());
        end
        if (exp_q.size() > 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s timeout: got %0d writes still outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // ---------------- test ----------------
    initial begin
        rst_i = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        step();
        step();

        //       rst iv ird dn drd dval          pv  ewb erd eval          emask         st ho ov
        add_vec(0,  0, 0,  0, 0,  32'h0,        0,  0,  0,  32'h0,        32'h0000_0000, 0, 0, 0);
        add_vec(1,  1, 5,  0, 0,  32'h0,        0,  0,  0,  32'h0,        32'h0000_0020, 0, 0, 0);
        add_vec(1,  0, 0,  0, 0,  32'h0,        0,  0,  0,  32'h0,        32'h0000_0020, 0, 0, 0);
        add_vec(1,  0, 0,  1, 5,  32'h2A,       0,  0,  0,  32'h0,        32'h0000_0020, 0, 0, 0);
        add_vec(1,  0, 0,  0, 0,  32'h0,        0,  1,  5,  32'h2A,       32'h0000_0020, 0, 0, 0);
        add_vec(1,  0, 0,  0, 0,  32'h0,        0,  0,  0,  32'h0,        32'h0000_0000, 0, 0, 0);
        add_vec(1,  0, 0,  1, 0,  32'hFFFF_FFFF,0,  0,  0,  32'h0,        32'h0000_0000, 0, 0, 0);
        add_vec(1,  0, 0,  0, 0,  32'h0,        0,  0,  0,  32'h0,        32'h0000_0000, 0, 0, 0);
        add_vec(1,  0, 0,  0, 0,  32'h0,        0,  0,  0,  32'h0,        32'h0000_0000, 0, 0, 0);
        add_vec(1,  1, 0,  0, 0,  32'h0,        0,  0,  0,  32'h0,        32'h0000_0000, 0, 0, 0);
        add_vec(1,  1, 3,  1, 7,  32'h1234,     1,  0,  0,  32'h0,        32'h0000_0008, 0, 0, 0);
        add_vec(1,  0, 0,  0, 0,  32'h0,        1,  0,  0,  32'h0,        32'h0000_0008, 0, 0, 0);
        add_vec(1,  0, 0,  0, 0,  32'h0,        0,  1,  7,  32'h1234,     32'h0000_0008, 0, 0, 0);
        add_vec(1,  1, 7,  0, 0,  32'h0,        0,  0,  0,  32'h0,        32'h0000_0088, 0, 0, 0);
        add_vec(1,  0, 0,  1, 3,  32'h5,        0,  0,  0,  32'h0,        32'h0000_0088, 0, 0, 0);
        add_vec(1,  0, 0,  0, 0,  32'h0,        0,  1,  3,  32'h5,        32'h0000_0088, 0, 0, 0);
        add_vec(1,  0, 0,  0, 0,  32'h0,        0,  0,  0,  32'h0,        32'h0000_0080, 0, 0, 0);

        foreach (vecs[i]) begin
            rst_i = vecs[i].rst;
            drive(vecs[i].iv, vecs[i].ird, vecs[i].dn, vecs[i].drd, vecs[i].dval, vecs[i].pv);
            step();
            chk($sformatf("vec%0d ctl", i),
                {wb_valid_o, pending_rd_mask_o, issue_stall_o, pipe_hold_o, overflow_o},
                {vecs[i].ewb, vecs[i].emask, vecs[i].estall, vecs[i].ehold, vecs[i].eovf});
            if (vecs[i].ewb)
                chk($sformatf("vec%0d data", i), {wb_rd_idx_o, wb_value_o}, {vecs[i].erd, vecs[i].eval});
        end
        rst_i = 1'b1;

        // Starvation: port held busy, two results queued, two forced pops 9 cycles apart.
        do_reset();
        exp_q.push_back({5'd1, 32'h11});
        exp_q.push_back({5'd2, 32'h22});
        for (int i = 1; i <= 19; i++) begin
            if (i == 1)      drive(0, 0, 1, 1, 32'h11, 1);
            else if (i == 2) drive(0, 0, 1, 2, 32'h22, 1);
            else             drive(0, 0, 0, 0, 0, 1);
            step();
            chk($sformatf("starve hold c%0d", i), pipe_hold_o, (i == 9 || i == 18));
            chk($sformatf("starve wb c%0d", i), wb_valid_o, (i == 10 || i == 19));
            if (wb_valid_o && exp_q.size() > 0)
                chk($sformatf("starve data c%0d", i), {wb_rd_idx_o, wb_value_o}, exp_q.pop_front());
        end
        chk("starve all drained", exp_q.size(), 0);

        // Fill, stall, overflow with a busy port; overflow is sticky.
        do_reset();
        drive(1, 9, 1, 1, 32'h301, 1); step();
        chk("fill1 stall/mask", {issue_stall_o, pending_rd_mask_o}, {1'b0, 32'h0000_0200});
        drive(0, 0, 1, 2, 32'h302, 1); step();
        chk("fill2 stall", issue_stall_o, 0);
        drive(0, 0, 1, 3, 32'h303, 1); step();
        chk("fill3 stall", issue_stall_o, 1);
        drive(0, 0, 1, 4, 32'h304, 1); step();
        chk("fill4 stall/ovf", {issue_stall_o, overflow_o}, {1'b1, 1'b0});
        drive(0, 0, 1, 9, 32'h309, 1); step();
        chk("drop ovf/mask", {overflow_o, pending_rd_mask_o, wb_valid_o}, {1'b1, 32'h0, 1'b0});
        for (int r = 1; r <= 4; r++) exp_q.push_back({5'(r), 32'h300 + 32'(r)});
        drain("overflow order", 12);
        chk("ovf sticky after drain", overflow_o, 1);
        drive(0, 0, 1, 6, 32'h306, 0); step();
        exp_q.push_back({5'd6, 32'h306});
        drain("post-ovf", 6);
        chk("ovf sticky late", overflow_o, 1);

        // Full FIFO with push and pop at the same edge: nothing lost, order kept.
        do_reset();
        for (int r = 1; r <= 4; r++) begin
            drive(0, 0, 1, 5'(r), 32'h100 + 32'(r), 1);
            step();
            exp_q.push_back({5'(r), 32'h100 + 32'(r)});
        end
        drive(0, 0, 1, 10, 32'h10A, 0);
        step();
        exp_q.push_back({5'd10, 32'h10A});
        chk("bypass ovf/stall/wb", {overflow_o, issue_stall_o, wb_valid_o}, {1'b0, 1'b1, 1'b1});
        if (wb_valid_o) chk("bypass first", {wb_rd_idx_o, wb_value_o}, exp_q.pop_front());
        drain("bypass order", 12);
        chk("bypass no ovf", overflow_o, 0);

        // Reset with three entries queued and mask 0xE0.
        do_reset();
        for (int r = 5; r <= 7; r++) begin
            drive(1, 5'(r), 1, 5'(r), 32'(r), 1);
            step();
        end
        chk("pre-reset mask/stall", {pending_rd_mask_o, issue_stall_o}, {32'h0000_00E0, 1'b1});
        rst_i = 1'b0;
        drive(0, 0, 1, 8, 32'h8, 1);
        step();
        rst_i = 1'b1;
        chk("reset outputs",
            {wb_valid_o, wb_rd_idx_o, wb_value_o, pending_rd_mask_o, issue_stall_o, pipe_hold_o, overflow_o},
            80'h0);
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("post-reset quiet c%0d", i), {wb_valid_o, pending_rd_mask_o}, 33'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
